pc_gen: RTL

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_if.sv | 34 +++
 rtl/pc_gen.sv | 123 ++++++++++++
 2 files changed

// File: rtl/pc_gen_if.sv
// Fetch-control bundle between the pipeline and the PC generator.
// The pipeline side drives the requests and the generator answers with fetch state.
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            jalr_valid;
    logic [XLEN-1:0] jalr_base;
    logic [XLEN-1:0] jalr_offset;
    logic            trap;
    logic            mret;
    logic            ras_push;
    logic            ras_pop;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] epc;
    logic            misaligned;
    logic            ras_empty;
    logic            ras_full;

    modport master (
        output stall, redirect_valid, redirect_target, jalr_valid, jalr_base,
               jalr_offset, trap, mret, ras_push, ras_pop,
        input  pc, pc_plus4, epc, misaligned, ras_empty, ras_full
    );

    modport slave (
        input  stall, redirect_valid, redirect_target, jalr_valid, jalr_base,
               jalr_offset, trap, mret, ras_push, ras_pop,
        output pc, pc_plus4, epc, misaligned, ras_empty, ras_full
    );
endinterface

// File: rtl/pc_gen.sv
// Program counter generator with prioritised redirects, trap/return handling
// and a circular return-address stack that overwrites its oldest entry when full.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h100),
    parameter int              RAS_DEPTH    = 4
) (
    input logic   clock,
    input logic   reset,
    pc_gen_if.slave bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] epc_reg, epc_next;
    logic            misaligned_reg, misaligned_next;
    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   top_reg, top_next;
    logic [CW-1:0]   count_reg, count_next;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] jalr_target;
    logic            ras_empty;
    logic            ras_full;
    logic            pop_hit;
    logic            hold;
    logic            do_push;
    logic            do_pop;
    logic [PW-1:0]   wr_idx;

    assign pc_plus4    = pc_reg + XLEN'(4);
    assign jalr_sum    = bus.jalr_base + bus.jalr_offset;
    assign jalr_target = {jalr_sum[XLEN-1:1], 1'b0};
    assign ras_empty   = (count_reg == '0);
    assign ras_full    = (count_reg == CW'(RAS_DEPTH));
    assign pop_hit     = bus.ras_pop && !ras_empty;

    always_comb begin
        pc_next         = pc_plus4;
        epc_next        = epc_reg;
        misaligned_next = 1'b0;
        hold            = 1'b0;
        if (bus.trap) begin
            pc_next  = TRAP_VECTOR;
            epc_next = pc_reg;
        end else if (bus.mret) begin
            pc_next = epc_reg;
        end else if (bus.jalr_valid) begin
            // bit 0 is already cleared, so only bit 1 can fault here
            if (jalr_target[1]) begin
                pc_next         = TRAP_VECTOR;
                epc_next        = pc_reg;
                misaligned_next = 1'b1;
            end else begin
                pc_next = jalr_target;
            end
        end else if (bus.redirect_valid) begin
            if (|bus.redirect_target[1:0]) begin
                pc_next         = TRAP_VECTOR;
                epc_next        = pc_reg;
                misaligned_next = 1'b1;
            end else begin
                pc_next = bus.redirect_target;
            end
        end else if (pop_hit) begin
            pc_next = ras_mem[top_reg];
        end else if (bus.stall) begin
            pc_next = pc_reg;
            hold    = 1'b1;
        end
    end

    // A plain stall freezes the stack; any redirect lets the call/return bookkeeping proceed.
    assign do_push = bus.ras_push && !hold;
    assign do_pop  = pop_hit && !hold;
    assign wr_idx  = do_pop ? top_reg : top_reg + PW'(1);

    always_comb begin
        top_next   = top_reg;
        count_next = count_reg;
        if (do_push && !do_pop) begin
            top_next = top_reg + PW'(1);
            if (!ras_full) begin
                count_next = count_reg + CW'(1);
            end
        end else if (do_pop && !do_push) begin
            top_next   = top_reg - PW'(1);
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg         <= RESET_VECTOR;
            epc_reg        <= '0;
            misaligned_reg <= 1'b0;
            top_reg        <= '0;
            count_reg      <= '0;
        end else begin
            pc_reg         <= pc_next;
            epc_reg        <= epc_next;
            misaligned_reg <= misaligned_next;
            top_reg        <= top_next;
            count_reg      <= count_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && do_push) begin
            ras_mem[wr_idx] <= pc_plus4;
        end
    end

    assign bus.pc         = pc_reg;
    assign bus.pc_plus4   = pc_plus4;
    assign bus.epc        = epc_reg;
    assign bus.misaligned = misaligned_reg;
    assign bus.ras_empty  = ras_empty;
    assign bus.ras_full   = ras_full;
endmodule
